// File: rtl/mem_arb_n_pkg.sv
// mem_arb_n_pkg: shared types for the N-client memory arbiter.
// Arbitration mode, FSM state and operation enums plus the client-ID width helper.
package mem_arb_n_pkg;

  typedef enum logic [1:0] {
    ARB_FIXED = 2'd0,
    ARB_LIST  = 2'd1,
    ARB_RR    = 2'd2,
    ARB_RSVD  = 2'd3
  } arb_mode_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Client ID width; never narrower than one bit.
  function automatic int cw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_n_if.sv
// mem_arb_n_if: client, memory and configuration bundle of mem_arb_n.
// slave = arbiter side, master = clients/memory/config side.
interface mem_arb_n_if
  import mem_arb_n_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8
);
  localparam int CW = cw_of(NUM_CLIENTS);

  logic                            en;
  logic [1:0]                      mode;
  logic [NUM_CLIENTS*CW-1:0]       prio_list;
  logic [NUM_CLIENTS-1:0]          c_rd;
  logic [NUM_CLIENTS-1:0]          c_wr;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] c_addr;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0] c_wr_data;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0] c_rd_data;
  logic [NUM_CLIENTS-1:0]          c_ack;
  logic                            m_rd;
  logic                            m_wr;
  logic [ADDR_WIDTH-1:0]           m_addr;
  logic [DATA_WIDTH-1:0]           m_wr_data;
  logic [DATA_WIDTH-1:0]           m_rd_data;
  logic                            m_ack;
  logic [CW-1:0]                   grant_id;
  logic                            busy;
  logic                            timeout_err;

  modport slave (
    input  en, mode, prio_list,
    input  c_rd, c_wr, c_addr, c_wr_data,
    input  m_rd_data, m_ack,
    output c_rd_data, c_ack,
    output m_rd, m_wr, m_addr, m_wr_data,
    output grant_id, busy, timeout_err
  );

  modport master (
    output en, mode, prio_list,
    output c_rd, c_wr, c_addr, c_wr_data,
    output m_rd_data, m_ack,
    input  c_rd_data, c_ack,
    input  m_rd, m_wr, m_addr, m_wr_data,
    input  grant_id, busy, timeout_err
  );

endinterface

// File: rtl/mem_arb_n_pick.sv
// mem_arb_n_pick: combinational winner select (fixed/list/round-robin).
// Ports: req, mode, prio_list, ptr, starved in; win (client ID) out.
module mem_arb_n_pick
  import mem_arb_n_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int CW          = cw_of(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0]    req,
  input  arb_mode_t                 mode,
  input  logic [NUM_CLIENTS*CW-1:0] prio_list,
  input  logic [CW-1:0]             ptr,
  input  logic [NUM_CLIENTS-1:0]    starved,
  output logic [CW-1:0]             win
);
  localparam int N = NUM_CLIENTS;

  logic          found;
  logic [N-1:0]  st;
  logic [CW-1:0] id;
  logic [CW-1:0] ri;
  int            idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    st    = starved & req;
    id    = '0;
    ri    = '0;
    idx   = 0;
    // A starved requester overrides every mode.
    if (|st) begin
      for (int i = 0; i < N; i++) begin
        if (!found && st[i]) begin
          win   = CW'(i);
          found = 1'b1;
        end
      end
    end else begin
      unique case (mode)
        ARB_LIST: begin
          for (int i = 0; i < N; i++) begin
            id = prio_list[i*CW +: CW];
            if (!found && (int'(id) < N)) begin
              if (req[id]) begin
                win   = id;
                found = 1'b1;
              end
            end
          end
        end
        ARB_RR: begin
          for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            ri = CW'(idx);
            if (!found && req[ri]) begin
              win   = ri;
              found = 1'b1;
            end
          end
        end
        ARB_FIXED, ARB_RSVD: begin
          for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
              win   = CW'(i);
              found = 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_arb_n.sv
// mem_arb_n: N-client memory arbiter with holding regs and anti-starvation.
// Ports: clk, rst (async, active-high), bus (mem_arb_n_if.slave). Option: MEM_ARB_TIMEOUT_EN.
module mem_arb_n
  import mem_arb_n_pkg::*;
#(
  parameter int NUM_CLIENTS    = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int STARVE_LIMIT   = 7,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic       clk,
  input logic       rst,
  mem_arb_n_if.slave bus
);
  localparam int N  = NUM_CLIENTS;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int CW = cw_of(N);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  if (N < 2 || N > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mem_arb_n: unsupported parameters");
  end

  arb_state_t    state;
  op_t           op;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic [CW-1:0] gid;
  logic [CW-1:0] ptr;
  logic [CW-1:0] win;
  logic [SW-1:0] starve [N];
  logic [N-1:0]  req;
  logic [N-1:0]  starved;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_wr;
  logic          busy;
  logic          start;
  logic          to_hit;
  logic          done;

  always_comb begin
    req     = bus.c_rd | bus.c_wr;
    starved = '0;
    s_addr  = '0;
    s_wdata = '0;
    s_wr    = 1'b0;
    for (int i = 0; i < N; i++) begin
      starved[i] = (starve[i] == SW'(STARVE_LIMIT));
      if (CW'(i) == win) begin
        s_addr = bus.c_addr[i*AW +: AW];
        s_wr   = bus.c_wr[i];
        // Write wins over read; read captures no data.
        s_wdata = bus.c_wr[i] ? bus.c_wr_data[i*DW +: DW] : '0;
      end
    end
  end

  mem_arb_n_pick #(
    .NUM_CLIENTS(N),
    .CW(CW)
  ) u_pick (
    .req(req),
    .mode(arb_mode_t'(bus.mode)),
    .prio_list(bus.prio_list),
    .ptr(ptr),
    .starved(starved),
    .win(win)
  );

  assign busy  = (state == ARB_ACCESS);
  assign start = (state == ARB_IDLE) && bus.en && (|req) && !bus.m_ack;
  assign done  = busy && (bus.m_ack || to_hit);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  // A real ack in the limit cycle still completes normally.
  assign to_hit = busy && !bus.m_ack
               && (tcnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (start) begin
      tcnt <= '0;
    end else if (busy && !bus.m_ack && !to_hit) begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ARB_IDLE;
      op      <= OP_RD;
      h_addr  <= '0;
      h_wdata <= '0;
      gid     <= '0;
      ptr     <= '0;
      for (int i = 0; i < N; i++) starve[i] <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (start) begin
            state   <= ARB_ACCESS;
            gid     <= win;
            op      <= s_wr ? OP_WR : OP_RD;
            h_addr  <= s_addr;
            h_wdata <= s_wdata;
            for (int i = 0; i < N; i++) begin
              if (CW'(i) == win) begin
                starve[i] <= '0;
              end else if (req[i] && !starved[i]) begin
                starve[i] <= starve[i] + 1'b1;
              end
            end
          end
        end
        ARB_ACCESS: begin
          if (done) begin
            state <= ARB_IDLE;
            ptr   <= (gid == CW'(N - 1)) ? '0 : gid + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy        = busy;
    bus.grant_id    = gid;
    bus.timeout_err = to_hit;
    bus.m_rd        = busy && (op == OP_RD) && !to_hit;
    bus.m_wr        = busy && (op == OP_WR) && !to_hit;
    bus.m_addr      = busy ? h_addr : '0;
    bus.m_wr_data   = (busy && op == OP_WR) ? h_wdata : '0;
    bus.c_ack       = '0;
    bus.c_rd_data   = '0;
    if (done) begin
      for (int i = 0; i < N; i++) begin
        if (CW'(i) == gid) begin
          bus.c_ack[i] = 1'b1;
          if (op == OP_RD && !to_hit) begin
            bus.c_rd_data[i*DW +: DW] = bus.m_rd_data;
          end
        end
      end
    end
  end

endmodule

// File: doc/mem_arb_n.md
Name: mem_arb_n

Overview:
- Parametrised N-client memory arbiter; successor to the 3-client fixed/dynamic-priority arbiter.
- Multiplexes N simple-data-transfer (rd/wr/addr/data/ack) clients onto one memory port.
- Arbitration modes: fixed index order, programmable priority list, or round-robin. An anti-starvation override applies in every mode.
- Captures each granted request into holding registers, so the memory side sees stable values for the whole access.
- Sits between client masters and the memory controller; its configuration inputs are driven by the existing APB register block.

Parameters:
- NUM_CLIENTS, 4, number of client interfaces (2..16).
- ADDR_WIDTH, 8, address width of clients and memory.
- DATA_WIDTH, 8, data width of clients and memory.
- STARVE_LIMIT, 7, number of lost arbitrations before a client is forced to win.
- TIMEOUT_CYCLES, 255, cycles allowed in ACCESS before the access is aborted (used only with the optional feature).

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- en, in, 1, arbiter enable.
- mode, in, 2, 00 fixed index, 01 priority list, 10 round-robin, 11 reserved (treated as 00).
- prio_list, in, NUM_CLIENTS*CW, client IDs in priority order, entry 0 highest. CW = max(1, clog2(NUM_CLIENTS)).
- c_rd, in, NUM_CLIENTS, per-client read request.
- c_wr, in, NUM_CLIENTS, per-client write request.
- c_addr, in, NUM_CLIENTS*ADDR_WIDTH, packed client addresses.
- c_wr_data, in, NUM_CLIENTS*DATA_WIDTH, packed client write data.
- c_rd_data, out, NUM_CLIENTS*DATA_WIDTH, packed client read data.
- c_ack, out, NUM_CLIENTS, per-client completion.
- m_rd, out, 1, memory read.
- m_wr, out, 1, memory write.
- m_addr, out, ADDR_WIDTH, memory address.
- m_wr_data, out, DATA_WIDTH, memory write data.
- m_rd_data, in, DATA_WIDTH, memory read data.
- m_ack, in, 1, memory completion.
- grant_id, out, CW, client currently granted.
- busy, out, 1, high while state is ACCESS.
- timeout_err, out, 1, one-cycle abort pulse.

Behaviour:
- Reset values: all outputs 0. State IDLE, round-robin pointer 0, starvation counters 0, holding registers 0.
- States are IDLE and ACCESS.
- IDLE → ACCESS when en && |(c_rd|c_wr) && !m_ack. On that clock edge: grant_id ← winner; hold registers capture op, addr and wr_data from the winner. If both c_rd and c_wr are set, write wins.
- ACCESS:
  - m_wr or m_rd = 1 per the captured op; m_addr and m_wr_data come from the hold registers.
  - Fields that do not apply are 0 (m_wr_data = 0 on a read).
  - When m_ack = 1: combinationally drive c_ack[grant_id] = 1 and, on a read, c_rd_data slice = m_rd_data. State returns to IDLE next cycle.
- Minimum cost is 2 cycles per access; no back-to-back grant without passing through IDLE.
- Winner selection, computed combinationally in IDLE:
  - Mode 00: lowest requesting index wins.
  - Mode 01: first prio_list entry that is requesting wins. Entries ≥ NUM_CLIENTS are skipped; a client absent from the list wins only through starvation.
  - Mode 10: first requester found scanning upward from the pointer, with wrap. On completion the pointer ← (grant_id+1) mod NUM_CLIENTS.
- Starvation:
  - On every grant, each requesting but non-granted client's counter increments, saturating at STARVE_LIMIT. The granted client's counter clears.
  - Any client whose counter equals STARVE_LIMIT overrides the mode; among several, the lowest index wins.
- en deassertion during ACCESS: the current access completes; no new grant is made.
- mode or prio_list change: affects only the next IDLE decision.
- Client request drop during ACCESS: ignored; the captured op completes and c_ack is still pulsed.
- c_ack and c_rd_data are 0 for all non-granted clients and in IDLE.
- Reset asserted mid-access: outputs drop to 0 immediately (asynchronous); no ack is issued.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on ACCESS entry and increments each ACCESS cycle without m_ack.
  - When it reaches TIMEOUT_CYCLES: m_rd and m_wr drop, timeout_err pulses for 1 cycle, and c_ack[grant_id] pulses with c_rd_data = 0. State returns to IDLE next cycle.
- Undefined: no counter; ACCESS waits indefinitely; timeout_err is tied 0.

Decomposition:
- Package mem_arb_n_pkg holds:
  - enum arb_mode_t {ARB_FIXED, ARB_LIST, ARB_RR, ARB_RSVD};
  - enum arb_state_t {ARB_IDLE, ARB_ACCESS};
  - typedef op_t {OP_RD, OP_WR}.
- Sub-module mem_arb_n_pick: combinational winner selection. Inputs are requests, mode, prio_list, pointer and starved mask; output is winner ID. It is unit-testable alone.

Test Plan (NUM_CLIENTS=4, STARVE_LIMIT=7):
- Fixed mode, clients 1 and 3 both read at addr 0x10/0x30, memory acks after 2 cycles with 0xA5 → client 1 served first: m_addr=0x10, c_ack[1]=1, c_rd_data[1]=0xA5. Client 3 is served next.
- Round-robin, all 4 requesting continuously → grant sequence 0,1,2,3,0; exactly one c_ack per grant.
- List mode, prio_list={2,0,3,1}, clients 0 and 2 requesting → grant 2. After client 2 drops its request → grant 0.
- List mode, prio_list={0,0,0,0}, clients 0 and 1 requesting continuously → client 1 wins on the 8th arbitration, then its counter clears.
- Client 0 raises c_rd and c_wr together with wr_data 0x3C → m_wr=1, m_rd=0, m_wr_data=0x3C. The captured values are held even when the client changes addr mid-access.
- With the macro defined, m_ack held 0 → timeout_err and c_ack[grant_id] pulse exactly once after 255 ACCESS cycles, then IDLE. Separately, rst asserted mid-ACCESS → all outputs 0 in the same cycle.
